// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, pipeline stall
// vectors, reset level and the stall priority helper.
package bus_arbiter_pkg;

  // Arbiter states: at most one shared-bus transaction is in flight.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_IF_ACCESS  = 2'b01,
    ST_MEM_ACCESS = 2'b10
  } arb_state_e;

  // Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Level of the reset input that clears all state.
  localparam logic RESET_ENABLE = 1'b0;

  // Stall priority: a waiting data access freezes the most stages, then a
  // busy multi-cycle EX op, then a waiting instruction fetch.
  function automatic logic [5:0] stall_vector(input logic mem_pending,
                                              input logic ex_stall,
                                              input logic if_pending);
    logic [5:0] result;
    if (mem_pending) begin
      result = STALL_MEM;
    end else if (ex_stall) begin
      result = STALL_EX;
    end else if (if_pending) begin
      result = STALL_IF;
    end else begin
      result = STALL_NONE;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_result_buffer.sv
// Result buffer for one requesting port: holds the last data returned by the
// bus and a valid flag telling the pipeline the result is ready.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-low reset
//   hold             : pipeline stall bit of the consuming stage; while low the
//                      stage advances and the valid flag is consumed (cleared)
//   set              : bus transaction for this port completes this cycle
//   data_in          : bus read data to capture on set
//   valid, data      : buffered result
module bus_result_buffer
  import bus_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        set,
  input  logic [31:0] data_in,
  output logic        valid,
  output logic [31:0] data
);

  logic        valid_r;
  logic [31:0] data_r;

  // Valid/data register; a completion only survives if the stage is held,
  // otherwise the consuming stage advances on this same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      valid_r <= 1'b0;
      data_r  <= 32'h0000_0000;
    end else begin
      if (set) begin
        data_r <= data_in;
      end else begin
        data_r <= data_r;
      end
      if (hold) begin
        valid_r <= valid_r | set;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter sharing one memory bus between the instruction fetch port and the
// data access port of a pipelined CPU. Data accesses win ties; an access in
// flight is never aborted. Results are buffered per port and the pipeline
// stall vector is derived from which port is still waiting.
// Ports:
//   clock, reset                    : clock and asynchronous active-low reset
//   if_request/if_address/if_data   : instruction fetch port
//   mem_request/mem_write/mem_address/mem_write_data/mem_select/mem_read_data
//                                   : data access port
//   ex_stall_request                : multi-cycle EX operation busy
//   bus_*                           : shared memory bus
//   stall                           : per-stage pipeline stall vector
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_request,
  input  logic [31:0] if_address,
  output logic [31:0] if_data,
  input  logic        mem_request,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_select,
  output logic [31:0] mem_read_data,
  input  logic        ex_stall_request,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_select,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data,
  output logic [5:0]  stall
);

  arb_state_e  state_r;
  arb_state_e  state_next_s;
  logic        launch_if_s;
  logic        launch_mem_s;
  logic        if_valid_s;
  logic        mem_valid_s;
  logic        if_pending_s;
  logic        mem_pending_s;
  logic        if_done_s;
  logic        mem_done_s;
  logic [5:0]  stall_s;
  logic        bus_write_r;
  logic [31:0] bus_address_r;
  logic [31:0] bus_write_data_r;
  logic [3:0]  bus_select_r;

  assign if_pending_s  = if_request  & ~if_valid_s;
  assign mem_pending_s = mem_request & ~mem_valid_s;
  assign stall_s       = stall_vector(mem_pending_s, ex_stall_request, if_pending_s);
  assign if_done_s     = (state_r == ST_IF_ACCESS)  & bus_ready;
  assign mem_done_s    = (state_r == ST_MEM_ACCESS) & bus_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and launch strobes; bus_ready only matters while accessing.
  always_comb begin
    state_next_s = state_r;
    launch_if_s  = 1'b0;
    launch_mem_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_pending_s) begin
          state_next_s = ST_MEM_ACCESS;
          launch_mem_s = 1'b1;
        end else if (if_pending_s) begin
          state_next_s = ST_IF_ACCESS;
          launch_if_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_IF_ACCESS: begin
        if (bus_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_IF_ACCESS;
        end
      end
      ST_MEM_ACCESS: begin
        if (bus_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_MEM_ACCESS;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bus command registers, loaded only when a transaction launches so they
  // stay constant for the whole access.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      bus_write_r      <= 1'b0;
      bus_address_r    <= 32'h0000_0000;
      bus_write_data_r <= 32'h0000_0000;
      bus_select_r     <= 4'b0000;
    end else if (launch_mem_s) begin
      bus_write_r      <= mem_write;
      bus_address_r    <= mem_address;
      bus_write_data_r <= mem_write_data;
      bus_select_r     <= mem_select;
    end else if (launch_if_s) begin
      bus_write_r      <= 1'b0;
      bus_address_r    <= if_address;
      bus_write_data_r <= 32'h0000_0000;
      bus_select_r     <= 4'b1111;
    end else begin
      bus_write_r      <= bus_write_r;
      bus_address_r    <= bus_address_r;
      bus_write_data_r <= bus_write_data_r;
      bus_select_r     <= bus_select_r;
    end
  end

  // IF result is consumed when the IF/ID stage advances (stall bit 1).
  bus_result_buffer u_if_buffer (
    .clock   (clock),
    .reset   (reset),
    .hold    (stall_s[1]),
    .set     (if_done_s),
    .data_in (bus_read_data),
    .valid   (if_valid_s),
    .data    (if_data)
  );

  // MEM result is consumed when the MEM/WB stage advances (stall bit 4).
  bus_result_buffer u_mem_buffer (
    .clock   (clock),
    .reset   (reset),
    .hold    (stall_s[4]),
    .set     (mem_done_s),
    .data_in (bus_read_data),
    .valid   (mem_valid_s),
    .data    (mem_read_data)
  );

  // Decoded from the state register, so reset drops it immediately.
  assign bus_request    = (state_r != ST_IDLE);
  assign bus_write      = bus_write_r;
  assign bus_address    = bus_address_r;
  assign bus_write_data = bus_write_data_r;
  assign bus_select     = bus_select_r;
  assign stall          = stall_s;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_request = 1'b0;
  logic [31:0] if_address = 32'd0;
  logic [31:0] if_data;
  logic        mem_request = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = 32'd0;
  logic [31:0] mem_write_data = 32'd0;
  logic [3:0]  mem_select = 4'd0;
  logic [31:0] mem_read_data;
  logic        ex_stall_request = 1'b0;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_select;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = 32'd0;
  logic [5:0]  stall;

  bus_arbiter dut (
    .clock(clock), .reset(reset),
    .if_request(if_request), .if_address(if_address), .if_data(if_data),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_select(mem_select),
    .mem_read_data(mem_read_data), .ex_stall_request(ex_stall_request),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_select(bus_select),
    .bus_ready(bus_ready), .bus_read_data(bus_read_data), .stall(stall)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which port owns the transaction in flight (0 none,
  // 1 fetch, 2 data), the command it issued, and per-port result buffers.
  int          m_owner = 0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [3:0]  m_sel = 4'd0;
  logic        m_write = 1'b0;
  logic        m_if_valid = 1'b0;
  logic        m_mem_valid = 1'b0;
  logic [31:0] m_if_buf = 32'd0;
  logic [31:0] m_mem_buf = 32'd0;

  // Values observed in the most recent cycle, for directed scenario checks.
  logic [5:0]  obs_stall;
  logic        obs_breq;
  logic [31:0] obs_addr;
  logic        obs_write;
  logic [3:0]  obs_sel;
  logic [31:0] obs_if_data;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_stall(input logic mp, input logic ex, input logic ip);
    if (mp) return 6'b011111;
    if (ex) return 6'b001111;
    if (ip) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_addr = 32'd0; m_wdata = 32'd0; m_sel = 4'd0; m_write = 1'b0;
    m_if_valid = 1'b0; m_mem_valid = 1'b0; m_if_buf = 32'd0; m_mem_buf = 32'd0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs against
  // the model, then advance the model across the rising edge.
  task automatic cycle(input logic ifr, input logic [31:0] ifa,
                       input logic mr, input logic mw, input logic [31:0] ma,
                       input logic [31:0] md, input logic [3:0] ms,
                       input logic ex, input logic rdy, input logic [31:0] rd);
    logic mp, ip, set_if, set_mem;
    logic [5:0] es;
    @(negedge clock);
    if_request = ifr; if_address = ifa;
    mem_request = mr; mem_write = mw; mem_address = ma; mem_write_data = md; mem_select = ms;
    ex_stall_request = ex; bus_ready = rdy; bus_read_data = rd;
    #1;
    mp = mr && !m_mem_valid;
    ip = ifr && !m_if_valid;
    es = exp_stall(mp, ex, ip);
    check_value("stall", {26'd0, stall}, {26'd0, es});
    check_value("bus_request", {31'd0, bus_request}, (m_owner != 0) ? 32'd1 : 32'd0);
    if (m_owner != 0) begin
      check_value("bus_address", bus_address, m_addr);
      check_value("bus_write", {31'd0, bus_write}, {31'd0, m_write});
      check_value("bus_write_data", bus_write_data, m_wdata);
      check_value("bus_select", {28'd0, bus_select}, {28'd0, m_sel});
    end
    check_value("if_data", if_data, m_if_buf);
    check_value("mem_read_data", mem_read_data, m_mem_buf);
    obs_stall = stall; obs_breq = bus_request; obs_addr = bus_address;
    obs_write = bus_write; obs_sel = bus_select; obs_if_data = if_data;
    @(posedge clock);
    set_if  = (m_owner == 1) && rdy;
    set_mem = (m_owner == 2) && rdy;
    if (set_if)  m_if_buf  = rd;
    if (set_mem) m_mem_buf = rd;
    m_if_valid  = es[1] ? (m_if_valid  || set_if)  : 1'b0;
    m_mem_valid = es[4] ? (m_mem_valid || set_mem) : 1'b0;
    if (m_owner == 0) begin
      if (mp) begin
        m_owner = 2; m_addr = ma; m_wdata = md; m_sel = ms; m_write = mw;
      end else if (ip) begin
        m_owner = 1; m_addr = ifa; m_wdata = 32'd0; m_sel = 4'b1111; m_write = 1'b0;
      end
    end else if (rdy) begin
      m_owner = 0;
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    int cnt, breq_cnt, fetch_cnt;

    // Reset state.
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_value("rst_bus_request", {31'd0, bus_request}, 32'd0);
    check_value("rst_bus_address", bus_address, 32'd0);
    check_value("rst_bus_select", {28'd0, bus_select}, 32'd0);
    check_value("rst_stall", {26'd0, stall}, 32'd0);
    check_value("rst_if_data", if_data, 32'd0);
    reset = 1'b1;

    // Fetch with bus_ready three cycles after the access starts.
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, (i == 3), 32'h2402_0005);
      if (obs_stall == 6'b000011) cnt++;
    end
    check_value("fetch_stall_cycles", cnt, 32'd4);
    idle_cycle();
    check_value("fetch_if_data", obs_if_data, 32'h2402_0005);
    check_value("fetch_released", {26'd0, obs_stall}, 32'd0);

    // Simultaneous fetch and data read: data first.
    cycle(1'b1, 32'h44, 1'b1, 1'b0, 32'h1000, 32'd0, 4'b1111, 1'b0, 1'b0, 32'd0);
    check_value("tie_stall_mem", {26'd0, obs_stall}, 32'h1f);
    cycle(1'b1, 32'h44, 1'b1, 1'b0, 32'h1000, 32'd0, 4'b1111, 1'b0, 1'b1, 32'hAAAA_5555);
    check_value("tie_first_addr", obs_addr, 32'h1000);
    cycle(1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    check_value("tie_stall_if", {26'd0, obs_stall}, 32'h03);
    cycle(1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'h1234_5678);
    check_value("tie_second_addr", obs_addr, 32'h44);
    idle_cycle();

    // Data write arriving while a fetch is in flight.
    fetch_cnt = 0;
    cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h80, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0, 32'd0);
    if (obs_breq && obs_addr == 32'h80) fetch_cnt++;
    cycle(1'b1, 32'h80, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b1, 32'h1111_1111);
    if (obs_breq && obs_addr == 32'h80) fetch_cnt++;
    cycle(1'b1, 32'h80, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0, 32'd0);
    if (obs_breq && obs_addr == 32'h80) fetch_cnt++;
    cycle(1'b1, 32'h80, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b1, 32'd0);
    if (obs_breq && obs_addr == 32'h80) fetch_cnt++;
    check_value("wr_bus_write", {31'd0, obs_write}, 32'd1);
    check_value("wr_bus_select", {28'd0, obs_sel}, 32'h3);
    cycle(1'b0, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    check_value("wr_if_kept", obs_if_data, 32'h1111_1111);
    check_value("wr_no_refetch_breq", {31'd0, obs_breq}, 32'd0);
    check_value("wr_fetch_cycles", fetch_cnt, 32'd2);

    // EX stall alone for five cycles.
    cnt = 0; breq_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
      if (obs_stall == 6'b001111) cnt++;
      if (obs_breq) breq_cnt++;
    end
    idle_cycle();
    if (obs_stall == 6'b001111) cnt++;
    check_value("ex_stall_cycles", cnt, 32'd5);
    check_value("ex_no_bus", breq_cnt, 32'd0);

    // Reset in the middle of a data access.
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h3000, 32'd0, 4'b1111, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_value("midrst_bus_request", {31'd0, bus_request}, 32'd0);
    check_value("midrst_stall", {26'd0, stall}, 32'h1f);
    check_value("midrst_bus_address", bus_address, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    check_value("midrst_held", {31'd0, bus_request}, 32'd0);
    reset = 1'b1;
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h3000, 32'd0, 4'b1111, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h3000, 32'd0, 4'b1111, 1'b0, 1'b1, 32'hCAFE_F00D);
    check_value("midrst_reissue_addr", obs_addr, 32'h3000);
    check_value("midrst_reissue_breq", {31'd0, obs_breq}, 32'd1);
    idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, $urandom % 2 == 1,
            $urandom, $urandom, 4'($urandom), ($urandom % 6) == 0,
            ($urandom % 3) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 resets all state immediately.
REQ-003 if_request  in  1 / if_address  in  32 / if_data  out  32: instruction fetch port.
REQ-004 mem_request  in  1 / mem_write  in  1 / mem_address  in  32 / mem_write_data  in  32 / mem_select  in  4 / mem_read_data  out  32: data access port.
REQ-005 ex_stall_request  in  1: multi-cycle EX op busy.
REQ-006 bus_request  out  1 / bus_write  out  1 / bus_address  out  32 / bus_write_data  out  32 / bus_select  out  4 / bus_ready  in  1 / bus_read_data  in  32: single shared memory bus.
REQ-007 stall  out  6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.

Function
REQ-008 States IDLE, IF_ACCESS, MEM_ACCESS; one bus transaction in flight max.
REQ-009 Per-port result buffers if_valid/if_buffer and mem_valid/mem_buffer; if_data = if_buffer, mem_read_data = mem_buffer.
REQ-010 Pending: if_pending = if_request & ~if_valid; mem_pending = mem_request & ~mem_valid.
REQ-011 IDLE: mem_pending -> MEM_ACCESS (priority); else if_pending -> IF_ACCESS; else stay.
REQ-012 On IDLE->ACCESS edge, register bus_address/bus_write_data/bus_select/bus_write from winning port; IF: select 4'b1111, write 0, write_data 0.
REQ-013 bus_request = 1 exactly while in IF_ACCESS or MEM_ACCESS; bus outputs constant during access.
REQ-014 ACCESS with bus_ready=1: capture bus_read_data into that port's buffer (writes capture too, value don't-care), set its valid, -> IDLE; bus_ready=0: stay, no timeout.
REQ-015 bus_ready ignored in IDLE.
REQ-016 stall combinational, priority: mem_pending -> 6'b011111; else ex_stall_request -> 6'b001111; else if_pending -> 6'b000011; else 6'b000000.
REQ-017 Valid clear: at edge with stall[1]=0, if_valid <= 0; at edge with stall[4]=0, mem_valid <= 0; clear and set in same edge -> set wins only if stall bit is 1.
REQ-018 IF result completing while mem stall active stays buffered; no re-fetch after stall lifts.
REQ-019 Same-cycle mem_pending and if_pending in IDLE: MEM served first, IF next IDLE cycle.
REQ-020 In-flight IF access is never aborted by new mem_request; MEM waits for completion.
REQ-021 Minimum latency: request cycle 0, bus_request cycle 1, bus_ready cycle 1 -> buffer valid cycle 2, stall released cycle 2.

Reset
REQ-022 reset=0 SHALL force IDLE, if_valid=mem_valid=0, buffers 0, all bus outputs 0, stall per REQ-016 from inputs.
REQ-023 Reset mid-access SHALL drop bus_request immediately; abandoned transaction not retried.

Structure
REQ-024 State encodings, stall vector constants (STALL_NONE, STALL_IF, STALL_EX, STALL_MEM), RESET_ENABLE level shared in the common defines package.
REQ-025 Single flat module; optional sub-module bus_result_buffer for valid/data pairs (instantiated twice).

Verification
REQ-026 Fetch 0x00000040, bus_ready 3 cycles later, data 0x24020005 -> stall 000011 for 4 cycles, if_data=0x24020005, then 000000.
REQ-027 Same-cycle if_request (0x44) and mem read 0x1000 -> bus_address 0x1000 first, stall 011111; then 0x44, stall 000011.
REQ-028 IF in flight, mem write 0xDEADBEEF to 0x2000 select 4'b0011 arrives -> IF completes, then bus_write=1, bus_select=0011; IF not refetched.
REQ-029 ex_stall_request 5 cycles, no memory -> stall 001111 for exactly 5 cycles, bus_request 0.
REQ-030 reset=0 during MEM_ACCESS -> bus_request 0 same cycle, IDLE, valids 0; after release, pending request reissued.
